// File: rtl/sample_unpacker_if.sv
// Chunk-in / frame-out bus between the sample fetcher, the unpacker and the I2S serializer.
// The unpacker is the slave; the environment (fetcher + serializer) is the master.
interface sample_unpacker_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [63:0]   chunk;
   logic          chunk_valid;
   logic          chunk_ack;
   logic          frame_req;
   logic          mute;
   logic [15:0]   frame_left;
   logic [15:0]   frame_right;
   logic          frame_valid;
   logic          underflow;
   logic [LW-1:0] level;

   modport master (
      output chunk, chunk_valid, frame_req, mute,
      input  chunk_ack, frame_left, frame_right, frame_valid, underflow, level
   );

   modport slave (
      input  chunk, chunk_valid, frame_req, mute,
      output chunk_ack, frame_left, frame_right, frame_valid, underflow, level
   );
endinterface

// File: rtl/sample_unpacker.sv
// Buffers 64-bit sample chunks and hands out one 16/16 stereo frame per I2S request.
// Optional macro SAMPLE_UNPACKER_HOLD_EN: underflow frame repeats the last served frame.
//
// state    | meaning
// ST_PRIME | refilling; requests get zero frames, no data consumed
// ST_RUN   | playing; requests consume frames, empty FIFO -> underflow
module sample_unpacker #(
   parameter int DEPTH = 4
) (
   input logic             clock,
   input logic             reset,
   sample_unpacker_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sample_unpacker: DEPTH must be a power of two >= 2");
   end

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level_q, level_nxt;
   logic          half, half_nxt;
   logic [15:0]   left_q, right_q, left_nxt, right_nxt;
   logic [15:0]   raw_left, raw_right, sel_left, sel_right;
   logic [15:0]   uf_left, uf_right;
   logic          valid_q, valid_nxt, uf_q, uf_nxt;
   logic          full, empty, push, pop, served;
   logic [63:0]   head;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   // No bypass: a full FIFO refuses even if it pops this cycle.
   assign push  = bus.chunk_valid & ~full & ~reset;
   assign bus.chunk_ack = push;

   assign head      = mem[rd_ptr];
   assign sel_left  = half ? head[47:32] : head[15:0];
   assign sel_right = half ? head[63:48] : head[31:16];

`ifdef SAMPLE_UNPACKER_HOLD_EN
   logic [15:0] last_left, last_right;

   always_ff @(posedge clock) begin
      if (reset) begin
         last_left  <= '0;
         last_right <= '0;
      end else if (served) begin
         last_left  <= sel_left;
         last_right <= sel_right;
      end
   end

   assign uf_left  = last_left;
   assign uf_right = last_right;
`else
   assign uf_left  = '0;
   assign uf_right = '0;
`endif

   always_comb begin
      state_nxt = state;
      half_nxt  = half;
      pop       = 1'b0;
      served    = 1'b0;
      valid_nxt = 1'b0;
      uf_nxt    = 1'b0;
      raw_left  = '0;
      raw_right = '0;
      left_nxt  = left_q;
      right_nxt = right_q;
      case (state)
         ST_PRIME: begin
            if (bus.frame_req) begin
               valid_nxt = 1'b1;
            end
            if (full) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.frame_req) begin
               valid_nxt = 1'b1;
               if (!empty) begin
                  served    = 1'b1;
                  raw_left  = sel_left;
                  raw_right = sel_right;
                  half_nxt  = ~half;
                  pop       = half;
               end else begin
                  uf_nxt    = 1'b1;
                  raw_left  = uf_left;
                  raw_right = uf_right;
                  half_nxt  = 1'b0;
                  state_nxt = ST_PRIME;
               end
            end
         end
         default: state_nxt = ST_PRIME;
      endcase
      if (valid_nxt) begin
         left_nxt  = bus.mute ? '0 : raw_left;
         right_nxt = bus.mute ? '0 : raw_right;
      end
   end

   always_comb begin
      level_nxt = level_q;
      case ({push, pop})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_PRIME;
         half    <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         left_q  <= '0;
         right_q <= '0;
         valid_q <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         half    <= half_nxt;
         level_q <= level_nxt;
         left_q  <= left_nxt;
         right_q <= right_nxt;
         valid_q <= valid_nxt;
         uf_q    <= uf_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Storage needs no reset; the pointers and level define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= bus.chunk;
      end
   end

   assign bus.frame_left  = left_q;
   assign bus.frame_right = right_q;
   assign bus.frame_valid = valid_q;
   assign bus.underflow   = uf_q;
   assign bus.level       = level_q;
endmodule

// File: tb/tb_sample_unpacker.sv
// Directed bench for sample_unpacker (DEPTH = 4); inputs change and outputs are checked on the falling edge.
module tb_sample_unpacker;
   logic clock;
   logic reset;
   int   checks;
   int   failures;

   sample_unpacker_if #(.DEPTH(4)) bus ();

   sample_unpacker #(.DEPTH(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // chunk i holds frames 2i and 2i+1; frame n is L=2n+1, R=2n+2
   function automatic logic [63:0] mk_chunk(input int i);
      logic [15:0] l0, r0, l1, r1;
      l0 = 16'(4 * i + 1);
      r0 = 16'(4 * i + 2);
      l1 = 16'(4 * i + 3);
      r1 = 16'(4 * i + 4);
      return {r1, l1, r0, l0};
   endfunction

   task automatic push(input int i);
      bus.chunk       = mk_chunk(i);
      bus.chunk_valid = 1'b1;
      #1;
      chk("push_ack", 64'(bus.chunk_ack), 64'd1);
      step();
      bus.chunk_valid = 1'b0;
   endtask

   task automatic req(input string tag, input logic [15:0] l, input logic [15:0] r,
                      input logic uf, input int lvl);
      bus.frame_req = 1'b1;
      step();
      bus.frame_req = 1'b0;
      chk({tag, "_left"},  64'(bus.frame_left),  64'(l));
      chk({tag, "_right"}, 64'(bus.frame_right), 64'(r));
      chk({tag, "_valid"}, 64'(bus.frame_valid), 64'd1);
      chk({tag, "_uf"},    64'(bus.underflow),   64'(uf));
      chk({tag, "_level"}, 64'(bus.level),       64'(lvl));
   endtask

   initial begin
      logic [15:0] uf_l, uf_r;
      checks          = 0;
      failures        = 0;
      reset           = 1'b1;
      bus.chunk       = '0;
      bus.chunk_valid = 1'b1;
      bus.frame_req   = 1'b1;
      bus.mute        = 1'b0;
`ifdef SAMPLE_UNPACKER_HOLD_EN
      uf_l = 16'h000F;
      uf_r = 16'h0010;
`else
      uf_l = 16'h0000;
      uf_r = 16'h0000;
`endif

      // reset state; requests and chunks offered during reset are ignored
      step();
      step();
      #1;
      chk("rst_ack",   64'(bus.chunk_ack),   64'd0);
      chk("rst_left",  64'(bus.frame_left),  64'd0);
      chk("rst_right", 64'(bus.frame_right), 64'd0);
      chk("rst_valid", 64'(bus.frame_valid), 64'd0);
      chk("rst_uf",    64'(bus.underflow),   64'd0);
      chk("rst_level", 64'(bus.level),       64'd0);
      bus.chunk_valid = 1'b0;
      bus.frame_req   = 1'b0;
      step();
      reset = 1'b0;
      step();

      // fill, go to RUN, then play out 8 frames in order
      for (int i = 0; i < 4; i++) push(i);
      chk("fill_level", 64'(bus.level), 64'd4);
      step();
      step();
      for (int k = 0; k < 8; k++)
         req($sformatf("play%0d", k), 16'(2 * k + 1), 16'(2 * k + 2), 1'b0, 4 - (k + 1) / 2);
      step();
      chk("pulse_valid", 64'(bus.frame_valid), 64'd0);
      chk("hold_left",   64'(bus.frame_left),  64'h000F);
      chk("hold_right",  64'(bus.frame_right), 64'h0010);

      // empty in RUN -> underflow frame, then PRIME zero frame
      req("uflow", uf_l, uf_r, 1'b1, 0);
      req("prime0", 16'h0, 16'h0, 1'b0, 0);
      step();
      chk("uf_pulse", 64'(bus.underflow), 64'd0);

      // PRIME with three chunks: zero frame, nothing consumed
      for (int i = 4; i < 7; i++) push(i);
      req("prime3", 16'h0, 16'h0, 1'b0, 3);
      push(7);
      step();
      step();
      chk("refill_level", 64'(bus.level), 64'd4);

      // full FIFO refuses until a pop frees an entry
      bus.chunk       = mk_chunk(8);
      bus.chunk_valid = 1'b1;
      #1;
      chk("full_noack", 64'(bus.chunk_ack), 64'd0);
      req("full0", 16'd17, 16'd18, 1'b0, 4);
      #1;
      chk("full_noack2", 64'(bus.chunk_ack), 64'd0);
      req("full1", 16'd19, 16'd20, 1'b0, 3);
      #1;
      chk("refill_ack", 64'(bus.chunk_ack), 64'd1);
      step();
      bus.chunk_valid = 1'b0;
      chk("refull_level", 64'(bus.level), 64'd4);

      // mute zeroes outputs but still consumes
      bus.mute = 1'b1;
      req("mute0", 16'h0, 16'h0, 1'b0, 4);
      req("mute1", 16'h0, 16'h0, 1'b0, 3);
      bus.mute = 1'b0;
      req("unmute", 16'd25, 16'd26, 1'b0, 3);

      // one-cycle reset with level 3 and half 1; request during reset ignored
      reset         = 1'b1;
      bus.frame_req = 1'b1;
      step();
      reset         = 1'b0;
      bus.frame_req = 1'b0;
      chk("mid_rst_left",  64'(bus.frame_left),  64'd0);
      chk("mid_rst_right", 64'(bus.frame_right), 64'd0);
      chk("mid_rst_valid", 64'(bus.frame_valid), 64'd0);
      chk("mid_rst_level", 64'(bus.level),       64'd0);
      req("post_rst", 16'h0, 16'h0, 1'b0, 0);

      // after reset, data restarts from frame 0 of the next chunk pushed
      for (int i = 9; i < 13; i++) push(i);
      step();
      step();
      req("restart", 16'd37, 16'd38, 1'b0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
